// File: rtl/zuma_cfg_pkg.sv
// zuma_cfg_pkg: shared constants, header layout and FSM states; ZUMA_CFG_CHECKSUM_EN adds the CHK state.
`ifndef ZUMA_LUT_SIZE
`define ZUMA_LUT_SIZE 6
`endif
package zuma_cfg_pkg;
  localparam logic [7:0] CFG_MAGIC = 8'hC5;
  localparam int MAGIC_LSB = 24;
  localparam int IDX_LSB = 0;
  localparam int IDX_W = 16;
`ifdef ZUMA_CFG_CHECKSUM_EN
  localparam int CHK_WORDS = 1;
  typedef enum logic [2:0] {ST_IDLE, ST_MASK, ST_DRAIN, ST_WRITE, ST_CHK} cfg_state_e;
  localparam cfg_state_e ST_AFTER_MASK = ST_CHK;
`else
  localparam int CHK_WORDS = 0;
  typedef enum logic [2:0] {ST_IDLE, ST_MASK, ST_DRAIN, ST_WRITE} cfg_state_e;
  localparam cfg_state_e ST_AFTER_MASK = ST_WRITE;
`endif
endpackage

// File: rtl/elut_config_writer_if.sv
// elut_config_writer_if: valid/ready config word stream.
interface elut_config_writer_if;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  modport master (output cfg_data, cfg_valid, input cfg_ready);
  modport slave (input cfg_data, cfg_valid, output cfg_ready);
endinterface

// File: rtl/elut_cfg_decoder.sv
// elut_cfg_decoder: registered LUT index to one-hot write enable.
module elut_cfg_decoder #(
  parameter int NUM_LUTS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [15:0]         idx_i,
  output logic [NUM_LUTS-1:0] we_o
);
  logic [NUM_LUTS-1:0] we_d;
  always_comb
    for (int i = 0; i < NUM_LUTS; i++) we_d[i] = en_i && idx_i == 16'(i);
  always_ff @(posedge clk)
    we_o <= rst_n ? we_d : '0;
endmodule

// File: rtl/elut_config_writer.sv
// elut_config_writer: header + mask word stream to bit-serial LUTRAM writes.
// Define ZUMA_CFG_CHECKSUM_EN to require a trailing XOR checksum word per record.
`ifndef ZUMA_LUT_SIZE
`define ZUMA_LUT_SIZE 6
`endif
module elut_config_writer
  import zuma_cfg_pkg::*;
#(
  parameter int ZUMA_LUT_SIZE = `ZUMA_LUT_SIZE,
  parameter int NUM_LUTS = 64,
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  elut_config_writer_if.slave  cfg,
  output logic [5:0]           lut_a,
  output logic                 lut_d,
  output logic [NUM_LUTS-1:0]  lut_we,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int MASK_BITS = 1 << ZUMA_LUT_SIZE;
  localparam int NW = MASK_BITS / WORD_W;
  cfg_state_e  state_q, state_d;
  logic [63:0] mask_q, mask_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic        err_q, err_d, done_q, dat_q, acc, wr_d;
  logic [7:0]  hdr_magic;
  logic [15:0] hdr_idx;
`ifdef ZUMA_CFG_CHECKSUM_EN
  logic [31:0] xsum_q, xsum_d;
`endif
  assign cfg.cfg_ready = rst_n && state_q != ST_WRITE;
  assign acc = cfg.cfg_valid && cfg.cfg_ready;
  assign hdr_magic = cfg.cfg_data[MAGIC_LSB +: 8];
  assign hdr_idx = cfg.cfg_data[IDX_LSB +: IDX_W];
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    err_d = err_q;
`ifdef ZUMA_CFG_CHECKSUM_EN
    xsum_d = xsum_q;
`endif
    case (state_q)
      ST_IDLE: if (acc) begin
        cnt_d = '0;
        if (hdr_magic != CFG_MAGIC) err_d = 1'b1;
        else if (32'(hdr_idx) < 32'(NUM_LUTS)) begin
          idx_d = hdr_idx;
          err_d = 1'b0;
          state_d = ST_MASK;
`ifdef ZUMA_CFG_CHECKSUM_EN
          xsum_d = cfg.cfg_data;
`endif
        end else begin
          err_d = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_MASK: if (acc) begin
        if (cnt_q[0]) mask_d[63:32] = cfg.cfg_data;
        else mask_d[31:0] = cfg.cfg_data;
        cnt_d = cnt_q + 2'd1;
`ifdef ZUMA_CFG_CHECKSUM_EN
        xsum_d = xsum_q ^ cfg.cfg_data;
`endif
        if (cnt_q == 2'(NW - 1)) state_d = ST_AFTER_MASK;
      end
      ST_DRAIN: if (acc) begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(NW + CHK_WORDS - 1)) state_d = ST_IDLE;
      end
`ifdef ZUMA_CFG_CHECKSUM_EN
      ST_CHK: if (acc) begin
        state_d = cfg.cfg_data == xsum_q ? ST_WRITE : ST_IDLE;
        err_d = cfg.cfg_data != xsum_q;
      end
`endif
      ST_WRITE: if (addr_q == 6'(MASK_BITS - 1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // Address/data are registered from next-state so they align with the decoder's registered enable.
  assign wr_d = state_d == ST_WRITE;
  assign addr_d = state_q == ST_WRITE ? addr_q + 6'd1 : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      dat_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
`ifdef ZUMA_CFG_CHECKSUM_EN
      xsum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      addr_q <= wr_d ? addr_d : '0;
      dat_q <= wr_d && mask_d[addr_d];
      err_q <= err_d;
      done_q <= state_q == ST_WRITE && state_d == ST_IDLE;
`ifdef ZUMA_CFG_CHECKSUM_EN
      xsum_q <= xsum_d;
`endif
    end
  end
  elut_cfg_decoder #(.NUM_LUTS(NUM_LUTS)) u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (wr_d),
    .idx_i (idx_q),
    .we_o  (lut_we)
  );
  assign lut_a = addr_q;
  assign lut_d = dat_q;
  assign busy = state_q != ST_IDLE;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_elut_config_writer.sv
// tb_elut_config_writer: directed checks of record loading, errors, stalls and reset (K=6, 64 LUTs).
module tb_elut_config_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] lut_a;
  logic lut_d, busy, done, err;
  logic [63:0] lut_we;
  int checks = 0;
  int errors = 0;
  elut_config_writer_if cfg_if ();
  elut_config_writer #(.ZUMA_LUT_SIZE(6), .NUM_LUTS(64), .WORD_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg    (cfg_if),
    .lut_a  (lut_a),
    .lut_d  (lut_d),
    .lut_we (lut_we),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic record(input logic [15:0] idx, input logic [31:0] m0, input logic [31:0] m1,
                        input bit stall, input int cut, input bit bad_sum);
    logic [31:0] hdr;
    logic [63:0] m;
    logic [31:0] w [2];
    hdr = {8'hC5, 8'h00, idx};
    m = {m1, m0};
    w[0] = m0;
    w[1] = m1;
    cfg_if.cfg_data = hdr;
    cfg_if.cfg_valid = 1'b1;
    @(negedge clk);
    chk("hdr_busy_err", {busy, err, cfg_if.cfg_ready}, 3'b101);
    for (int i = 0; i < 2; i++) begin
      if (stall) begin
        cfg_if.cfg_valid = 1'b0;
        @(negedge clk);
        chk("stall_idle", {busy, lut_we}, {1'b1, 64'd0});
      end
      cfg_if.cfg_data = w[i];
      cfg_if.cfg_valid = 1'b1;
      @(negedge clk);
    end
`ifdef ZUMA_CFG_CHECKSUM_EN
    cfg_if.cfg_data = hdr ^ m0 ^ m1 ^ {31'd0, bad_sum};
    cfg_if.cfg_valid = 1'b1;
    @(negedge clk);
`endif
    cfg_if.cfg_valid = 1'b0;
    if (bad_sum) begin
      chk("sum_bad", {err, busy, done, lut_we}, {3'b100, 64'd0});
      @(negedge clk);
      chk("sum_bad_quiet", {done, lut_we}, {1'b0, 64'd0});
    end else begin
      for (int k = 0; k < cut; k++) begin
        chk($sformatf("wr%0d", k), {done, cfg_if.cfg_ready, busy, lut_a, lut_d, lut_we},
            {1'b0, 1'b0, 1'b1, 6'(k), m[k], 64'd1 << idx});
        @(negedge clk);
      end
      if (cut == 64)
        chk("done", {done, cfg_if.cfg_ready, busy, lut_we}, {3'b110, 64'd0});
    end
  endtask
  initial begin
    cfg_if.cfg_data = '0;
    cfg_if.cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {cfg_if.cfg_ready, busy, done, err, lut_a, lut_d, lut_we}, '0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {cfg_if.cfg_ready, busy}, 2'b10);
    @(negedge clk);
    record(16'd5, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 64, 1'b0);
    record(16'd9, 32'hFFFF_0000, 32'h0000_8001, 1'b0, 64, 1'b0);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    cfg_if.cfg_data = 32'hA500_0001;
    cfg_if.cfg_valid = 1'b1;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    chk("bad_magic", {err, busy, cfg_if.cfg_ready, lut_we}, {3'b101, 64'd0});
    record(16'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64, 1'b0);
    cfg_if.cfg_data = 32'hC500_0040;
    cfg_if.cfg_valid = 1'b1;
    @(negedge clk);
    chk("oor_hdr", {err, busy, cfg_if.cfg_ready}, 3'b111);
    cfg_if.cfg_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("oor_drain", {cfg_if.cfg_ready, lut_we, done}, {1'b1, 64'd0, 1'b0});
    cfg_if.cfg_data = 32'hFFFF_FFFF;
    @(negedge clk);
`ifdef ZUMA_CFG_CHECKSUM_EN
    chk("oor_drain_sum", {busy, lut_we}, {1'b1, 64'd0});
    @(negedge clk);
`endif
    cfg_if.cfg_valid = 1'b0;
    chk("oor_end", {err, busy, done, lut_we}, {3'b100, 64'd0});
    @(negedge clk);
    chk("oor_quiet", {done, lut_we}, {1'b0, 64'd0});
    record(16'd63, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 64, 1'b0);
    @(negedge clk);
    record(16'd7, 32'h0F0F_3C3C, 32'hC3C3_F0F0, 1'b0, 20, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_write", {cfg_if.cfg_ready, busy, done, err, lut_a, lut_d, lut_we}, '0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst2", cfg_if.cfg_ready, 1'b1);
    record(16'd7, 32'h0F0F_3C3C, 32'hC3C3_F0F0, 1'b0, 64, 1'b0);
`ifdef ZUMA_CFG_CHECKSUM_EN
    @(negedge clk);
    record(16'd2, 32'h1111_2222, 32'h3333_4444, 1'b0, 64, 1'b1);
    record(16'd2, 32'h1111_2222, 32'h3333_4444, 1'b0, 64, 1'b0);
`endif
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/elut_config_writer.md
# elut_config_writer

Configuration loader sitting directly upstream of the LUTRAM write ports of the overlay's logic elements. Accepts a word stream of LUT configuration records over a valid/ready interface, buffers one LUT mask, and serialises it into bit-wise LUTRAM writes (address, data, one-hot write enable) targeting one of `NUM_LUTS` elements. Records with bad framing or an out-of-range index are consumed and flagged, never written.

## Interface
- `ZUMA_LUT_SIZE`, default `` `ZUMA_LUT_SIZE ``: LUT input count K; legal 5 or 6; mask is 2^K bits.
- `NUM_LUTS`, default 64: number of LUTRAMs driven; legal 1..65535.
- `WORD_W`, default 32: config word width; fixed at 32.
- `clk`, in, 1: sole clock, also the LUTRAM write clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cfg_data`, in, 32: config word.
- `cfg_valid`, in, 1: `cfg_data` valid.
- `cfg_ready`, out, 1: block accepts the word this cycle.
- `lut_a`, out, 6: LUTRAM write address; bit 5 is 0 when K=5.
- `lut_d`, out, 1: LUTRAM write data.
- `lut_we`, out, NUM_LUTS: one-hot write enable.
- `busy`, out, 1: record in progress (not IDLE).
- `done`, out, 1: one-cycle pulse after the last write of a record.
- `err`, out, 1: sticky error; cleared on next accepted valid header.

## Operation
- Transfer occurs on a cycle with `cfg_valid && cfg_ready`.
- Header word: [31:24] magic 8'hC5, [23:16] reserved (ignored), [15:0] LUT index.
- Mask words: W = 2^K/32 (1 for K=5, 2 for K=6); first word holds mask bits [31:0], second [63:32]. Mask bit i is written to address i.
- FSM states:
  - IDLE: ready=1. Bad magic: drop, set `err`, stay. Good magic, index < NUM_LUTS: latch index, clear `err`, go MASK. Good magic, index ≥ NUM_LUTS: set `err`, go DRAIN.
  - MASK: ready=1; accept W words into mask register; after the W-th word go WRITE (or CHK when the checksum option is enabled).
  - DRAIN: ready=1; consume W words (plus checksum word when enabled), discard, return to IDLE. No writes, no `done`.
  - WRITE: ready=0; 2^K cycles, address 0..2^K-1 ascending; `lut_we[index]`=1, `lut_d`=mask[addr]; then IDLE with `done`=1 for one cycle.
- Index-to-one-hot decode is registered together with `lut_a`/`lut_d`, so all three change on the same edge.
- `cfg_valid` low in any accepting state stalls with no state change; there is no timeout.

## Timing
- Reset: all outputs 0, including `cfg_ready`, which is forced to 0 while `rst_n` is low. State IDLE, mask and index cleared. `cfg_ready`=1 from the first cycle with `rst_n` high.
- Header accepted at T (K=6, no stalls): mask words at T+1 and T+2; writes on T+3..T+66; `done` at T+67, with `cfg_ready`=1 that same cycle. A new header may be accepted at T+67.
- K=5: writes on T+2..T+33; `done` at T+34.
- Reset mid-WRITE: `lut_we` is 0 from the first edge with `rst_n` low; the partially written LUT is undefined; no `done`.
- `done` and a new header acceptance may coincide; `err` clears on that acceptance.

## Configuration
- `ZUMA_CFG_CHECKSUM_EN` defined: each record carries one extra trailing word equal to the XOR of the header and all mask words. State CHK (ready=1) accepts it. On match, go WRITE. On mismatch, set `err`, go IDLE, no writes, no `done`. DRAIN also consumes this word.
- Undefined: no trailing word and no CHK state; MASK goes directly to WRITE.

## Structure
- Shared package `zuma_cfg_pkg`: magic constant 8'hC5, header field positions, FSM state enum, checksum word count derived from the macro.
- One sub-module, `elut_cfg_decoder`: registered index-to-one-hot `lut_we` generator with an enable input.

## Test plan
- K=6, NUM_LUTS=64; header 32'hC500_0005, masks 32'hDEAD_BEEF then 32'h0123_4567 -> 64 writes to `lut_we[5]` only; a=0 d=1, a=4 d=0, a=32 d=1; `done` at T+67.
- Header 32'hA500_0001 -> word dropped, `err`=1, no `lut_we`; next valid header clears `err`.
- Header 32'hC500_0040 (index 64) -> two mask words consumed, `err`=1, `lut_we` stays 0, no `done`.
- `cfg_valid` toggled 1/0 each cycle during MASK -> same write sequence, delayed only by the stall cycles.
- `rst_n` low at write cycle 20 -> `lut_we`=0 on the next edge; `busy`=0; after release a fresh record writes correctly.
- `ZUMA_CFG_CHECKSUM_EN`: correct XOR -> writes as in scenario 1; one checksum bit flipped -> `err`=1, zero writes.
